// File: rtl/ram_banked_pkg.sv
// Shared types and address helpers for the banked dual-port RAM.
// Struct fields are sized for the widest supported configuration (64-bit data and address).
package ram_banked_pkg;

    localparam int unsigned MaxAddrW = 64;
    localparam int unsigned MaxDataW = 64;
    localparam int unsigned MaxBeW   = MaxDataW / 8;

    typedef enum logic {PORT_A, PORT_B} port_t;

    typedef struct packed {
        logic [MaxAddrW-1:0] addr;
        logic                we;
        logic [MaxBeW-1:0]   be;
        logic [MaxDataW-1:0] wdata;
    } mem_req_t;

    // Words are interleaved across banks starting at address bit 2.
    function automatic int unsigned bank_idx(input logic [MaxAddrW-1:0] addr,
                                             input int unsigned banks);
        logic [MaxAddrW-1:0] w;
        w = (addr >> 2) & MaxAddrW'(banks - 1);
        return 32'(w);
    endfunction

    function automatic int unsigned row_idx(input logic [MaxAddrW-1:0] addr,
                                            input int unsigned banks,
                                            input int unsigned depth);
        logic [MaxAddrW-1:0] w;
        w = (addr >> (2 + $clog2(banks))) & MaxAddrW'(depth / banks - 1);
        return 32'(w);
    endfunction

endpackage

// File: rtl/ram_bank.sv
// Single-port byte-writable RAM bank with one-cycle registered read.
// With RAM_BANKED_PARITY_EN defined, stores an even-parity bit per byte and flags mismatches.
module ram_bank #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ROWS   = 2048,
    parameter int unsigned RW     = $clog2(ROWS)
) (
    input  logic                clk,
    input  logic                en_i,
    input  logic                we_i,
    input  logic [RW-1:0]       row_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                perr_o
);

    localparam int unsigned NB = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [ROWS];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < NB; i++) begin
                    if (be_i[i]) mem_q[row_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end else begin
                rdata_q <= mem_q[row_i];
            end
        end
    end

    assign rdata_o = rdata_q;

`ifdef RAM_BANKED_PARITY_EN
    logic [NB-1:0] par_q [ROWS];
    logic [NB-1:0] rpar_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < NB; i++) begin
                    if (be_i[i]) par_q[row_i][i] <= ^wdata_i[i*8 +: 8];
                end
            end else begin
                rpar_q <= par_q[row_i];
            end
        end
    end

    always_comb begin
        perr_o = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if ((^rdata_q[i*8 +: 8]) != rpar_q[i]) perr_o = 1'b1;
        end
    end
`else
    assign perr_o = 1'b0;
`endif

endmodule

// File: rtl/ram_banked_dp.sv
// Dual-port RAM over BANKS word-interleaved banks with round-robin same-bank arbitration.
// Optional per-byte parity checking is enabled by defining RAM_BANKED_PARITY_EN.
module ram_banked_dp
    import ram_banked_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned BANKS  = 2,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                a_req_i,
    output logic                a_gnt_o,
    input  logic [ADDR_W-1:0]   a_addr_i,
    input  logic                a_we_i,
    input  logic [DATA_W/8-1:0] a_be_i,
    input  logic [DATA_W-1:0]   a_wdata_i,
    output logic                a_rvalid_o,
    output logic [DATA_W-1:0]   a_rdata_o,
    output logic                a_err_o,

    input  logic                b_req_i,
    output logic                b_gnt_o,
    input  logic [ADDR_W-1:0]   b_addr_i,
    input  logic                b_we_i,
    input  logic [DATA_W/8-1:0] b_be_i,
    input  logic [DATA_W-1:0]   b_wdata_i,
    output logic                b_rvalid_o,
    output logic [DATA_W-1:0]   b_rdata_o,
    output logic                b_err_o
);

    localparam int unsigned NB   = DATA_W / 8;
    localparam int unsigned ROWS = DEPTH / BANKS;
    localparam int unsigned RW   = $clog2(ROWS);
    localparam int unsigned BW   = (BANKS > 1) ? $clog2(BANKS) : 1;

    mem_req_t        a_req_s, b_req_s;
    logic [BW-1:0]   a_bank, b_bank;
    logic            conflict;
    port_t           prio_q, prio_d;

    logic [DATA_W-1:0] bank_rdata [BANKS];
    logic [BANKS-1:0]  bank_perr;

    logic              a_valid_q, b_valid_q;
    logic              a_we_q, b_we_q;
    logic [BW-1:0]     a_bank_q, b_bank_q;
    logic [DATA_W-1:0] a_hold_q, b_hold_q;

    always_comb begin
        a_req_s       = '0;
        a_req_s.addr  = MaxAddrW'(a_addr_i);
        a_req_s.we    = a_we_i;
        a_req_s.be    = MaxBeW'(a_be_i);
        a_req_s.wdata = MaxDataW'(a_wdata_i);
        b_req_s       = '0;
        b_req_s.addr  = MaxAddrW'(b_addr_i);
        b_req_s.we    = b_we_i;
        b_req_s.be    = MaxBeW'(b_be_i);
        b_req_s.wdata = MaxDataW'(b_wdata_i);
    end

    assign a_bank   = BW'(bank_idx(a_req_s.addr, BANKS));
    assign b_bank   = BW'(bank_idx(b_req_s.addr, BANKS));
    assign conflict = a_req_i && b_req_i && (a_bank == b_bank);

    assign a_gnt_o = !rst && a_req_i && (!conflict || prio_q == PORT_A);
    assign b_gnt_o = !rst && b_req_i && (!conflict || prio_q == PORT_B);

    // The loser of a conflict gets priority next time, so sustained conflicts alternate.
    always_comb begin
        prio_d = prio_q;
        if (conflict) prio_d = (prio_q == PORT_A) ? PORT_B : PORT_A;
    end

    for (genvar k = 0; k < BANKS; k++) begin : g_bank
        logic     sel_a, sel_b;
        mem_req_t req;

        assign sel_a = a_gnt_o && (a_bank == BW'(k));
        assign sel_b = b_gnt_o && (b_bank == BW'(k));
        assign req   = sel_b ? b_req_s : a_req_s;

        ram_bank #(
            .DATA_W (DATA_W),
            .ROWS   (ROWS),
            .RW     (RW)
        ) u_bank (
            .clk     (clk),
            .en_i    (sel_a || sel_b),
            .we_i    (req.we),
            .row_i   (RW'(row_idx(req.addr, BANKS, DEPTH))),
            .be_i    (req.be[NB-1:0]),
            .wdata_i (req.wdata[DATA_W-1:0]),
            .rdata_o (bank_rdata[k]),
            .perr_o  (bank_perr[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q    <= PORT_A;
            a_valid_q <= 1'b0;
            a_we_q    <= 1'b0;
            a_bank_q  <= '0;
            a_hold_q  <= '0;
            b_valid_q <= 1'b0;
            b_we_q    <= 1'b0;
            b_bank_q  <= '0;
            b_hold_q  <= '0;
        end else begin
            prio_q    <= prio_d;
            a_valid_q <= a_gnt_o;
            a_we_q    <= a_we_i;
            a_bank_q  <= a_bank;
            b_valid_q <= b_gnt_o;
            b_we_q    <= b_we_i;
            b_bank_q  <= b_bank;
            if (a_valid_q && !a_we_q) a_hold_q <= bank_rdata[a_bank_q];
            if (b_valid_q && !b_we_q) b_hold_q <= bank_rdata[b_bank_q];
        end
    end

    // Read data comes straight from the bank register; writes replay the last read value.
    assign a_rvalid_o = a_valid_q;
    assign a_rdata_o  = (a_valid_q && !a_we_q) ? bank_rdata[a_bank_q] : a_hold_q;
    assign a_err_o    = a_valid_q && !a_we_q && bank_perr[a_bank_q];
    assign b_rvalid_o = b_valid_q;
    assign b_rdata_o  = (b_valid_q && !b_we_q) ? bank_rdata[b_bank_q] : b_hold_q;
    assign b_err_o    = b_valid_q && !b_we_q && bank_perr[b_bank_q];

endmodule
